// File: rtl/svm_dot_mac.sv
// rtl/svm_dot_mac.sv - LANES-wide dot-product MAC onto a signed bias with a held, handshaked result.
// Optional output clamp to the signed OBITS range enabled by SVM_DOT_MAC_SATURATE_EN.
module svm_dot_mac #(
  parameter int LANES = 4,
  parameter int ABITS = 8,
  parameter int BBITS = 12,
  parameter int PBITS = 40,
  parameter int OBITS = 32,
  parameter int LEN   = 64,
  parameter int CBITS = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [PBITS-1:0]   bias,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ABITS-1:0]    a,
  input  logic [LANES*BBITS-1:0]    b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OBITS-1:0]   result,
  output logic                      saturated,
  output logic                      busy
);

  localparam int MBITS = ABITS + BBITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

  state_t                   state_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     saturated_q;
  logic                     busy_q;
  logic                     pv_q;
  logic [CBITS-1:0]         count_q;
  logic signed [PBITS-1:0]  acc_q;
  logic signed [OBITS-1:0]  result_q;
  logic signed [PBITS-1:0]  prod_q [LANES];

  logic signed [MBITS-1:0]  mul_d  [LANES];
  logic signed [PBITS-1:0]  prod_d [LANES];
  logic signed [PBITS-1:0]  psum_d;
  logic signed [OBITS-1:0]  result_d;
  logic                     saturated_d;
  logic                     accept;

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign saturated = saturated_q;
  assign busy      = busy_q;

  // A is zero-extended and B sign-extended to MBITS so the signed product is exact.
  always_comb begin
    psum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      mul_d[i]  = $signed({{(BBITS+1){1'b0}}, a[i*ABITS +: ABITS]}) *
                  $signed({{(ABITS+1){b[i*BBITS+BBITS-1]}}, b[i*BBITS +: BBITS]});
      prod_d[i] = {{(PBITS-MBITS){mul_d[i][MBITS-1]}}, mul_d[i]};
      psum_d    = psum_d + prod_q[i];
    end
  end

`ifdef SVM_DOT_MAC_SATURATE_EN
  localparam logic signed [PBITS-1:0] OMAX = {{(PBITS-OBITS+1){1'b0}}, {(OBITS-1){1'b1}}};
  localparam logic signed [PBITS-1:0] OMIN = {{(PBITS-OBITS+1){1'b1}}, {(OBITS-1){1'b0}}};

  always_comb begin
    result_d    = acc_q[OBITS-1:0];
    saturated_d = 1'b0;
    if (acc_q > OMAX) begin
      result_d    = OMAX[OBITS-1:0];
      saturated_d = 1'b1;
    end else if (acc_q < OMIN) begin
      result_d    = OMIN[OBITS-1:0];
      saturated_d = 1'b1;
    end
  end
`else
  always_comb begin
    result_d    = acc_q[OBITS-1:0];
    saturated_d = 1'b0;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      saturated_q <= 1'b0;
      busy_q      <= 1'b0;
      pv_q        <= 1'b0;
      count_q     <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      pv_q <= accept;
      if (accept) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      end
      if (pv_q) acc_q <= acc_q + psum_d;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q      <= bias;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            count_q <= count_q + CBITS'(1);
            if (count_q == CBITS'(LEN - 1)) begin
              in_ready_q <= 1'b0;
              state_q    <= S_DRAIN;
            end
          end
        end
        // Wait until the last product has landed in the accumulator before sampling it.
        S_DRAIN: begin
          if (!pv_q) begin
            result_q    <= result_d;
            saturated_q <= saturated_d;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            saturated_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_dot_mac.sv
// tb/tb_svm_dot_mac.sv - self-checking bench for svm_dot_mac against a plain-arithmetic dot-product model.
module tb_svm_dot_mac;

  localparam int LANES = 4;
  localparam int ABITS = 8;
  localparam int BBITS = 12;
  localparam int PBITS = 40;
  localparam int OBITS = 32;
  localparam int LEN   = 4;
  localparam int CBITS = 16;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     start = 1'b0;
  logic signed [PBITS-1:0]  bias = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [LANES*ABITS-1:0]   a = '0;
  logic [LANES*BBITS-1:0]   b = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [OBITS-1:0]  result;
  logic                     saturated;
  logic                     busy;

  int tests = 0;
  int fails = 0;

  logic [LANES*ABITS-1:0] va [LEN];
  logic [LANES*BBITS-1:0] vb [LEN];

  always #5 clock = ~clock;

  svm_dot_mac #(
    .LANES(LANES), .ABITS(ABITS), .BBITS(BBITS), .PBITS(PBITS),
    .OBITS(OBITS), .LEN(LEN), .CBITS(CBITS)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .saturated(saturated), .busy(busy)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: exact integer dot product plus bias, wrapped to PBITS, then clamped or truncated.
  function automatic void model(input logic signed [PBITS-1:0] bi,
                                output logic [OBITS-1:0] r, output logic s);
    longint sum;
    logic signed [PBITS-1:0] w;
    logic [ABITS-1:0] ae;
    logic signed [BBITS-1:0] be;
    sum = longint'(bi);
    for (int j = 0; j < LEN; j++) begin
      for (int i = 0; i < LANES; i++) begin
        ae  = va[j][i*ABITS +: ABITS];
        be  = vb[j][i*BBITS +: BBITS];
        sum = sum + longint'({1'b0, ae}) * longint'(be);
      end
    end
    w = sum[PBITS-1:0];
`ifdef SVM_DOT_MAC_SATURATE_EN
    if (longint'(w) > 64'sd2147483647) begin
      r = 32'h7FFF_FFFF; s = 1'b1;
    end else if (longint'(w) < -64'sd2147483648) begin
      r = 32'h8000_0000; s = 1'b1;
    end else begin
      r = w[OBITS-1:0]; s = 1'b0;
    end
`else
    r = w[OBITS-1:0];
    s = 1'b0;
`endif
  endfunction

  task automatic fill_const(input logic [ABITS-1:0] av, input logic [BBITS-1:0] bv);
    for (int j = 0; j < LEN; j++) begin
      for (int i = 0; i < LANES; i++) begin
        va[j][i*ABITS +: ABITS] = av;
        vb[j][i*BBITS +: BBITS] = bv;
      end
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < LEN; j++) begin
      va[j] = $urandom();
      vb[j] = 48'({$urandom(), $urandom()});
    end
  endtask

  // One full vector: start, LEN beats with `gap` bubbles before each, result checks, handshake.
  task automatic run_vector(input string nm, input logic signed [PBITS-1:0] bi,
                            input int gap, input int hold_wait, input bit pulse_start);
    logic [OBITS-1:0] er;
    logic es;
    logic [OBITS-1:0] first_res;
    int t;
    model(bi, er, es);
    out_ready = (hold_wait == 0);
    start = 1'b1;
    bias  = bi;
    step();
    start = 1'b0;
    bias  = $signed(40'({$urandom(), $urandom()}));
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s start_accum: busy=%b in_ready=%b out_valid=%b, required 1 1 0", nm, busy, in_ready, out_valid);
    end
    for (int j = 0; j < LEN; j++) begin
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        a = $urandom();
        b = 48'({$urandom(), $urandom()});
        step();
      end
      in_valid = 1'b1;
      a = va[j];
      b = vb[j];
      t = 0;
      while (!in_ready && t < 10) begin
        step();
        t++;
      end
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL %s accept_timeout beat %0d: in_ready=%b, required 1", nm, j, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    a = $urandom();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s drain: out_valid=%b in_ready=%b busy=%b, required 0 0 1", nm, out_valid, in_ready, busy);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s latency_early: out_valid=%b in_ready=%b, required 0 0", nm, out_valid, in_ready);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s latency: out_valid=%b in_ready=%b, required 1 0", nm, out_valid, in_ready);
    end
    tests++;
    if (result !== er || saturated !== es) begin
      fails++;
      $display("FAIL %s result: got %0d sat=%b, required %0d sat=%b", nm, result, saturated, $signed(er), es);
    end
    first_res = result;
    for (int c = 0; c < hold_wait; c++) begin
      start = pulse_start && (c == 1);
      step();
      tests++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || result !== first_res) begin
        fails++;
        $display("FAIL %s hold_stable cycle %0d: out_valid=%b busy=%b result=%0d, required 1 1 %0d",
                 nm, c, out_valid, busy, result, $signed(first_res));
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s handshake: out_valid=%b busy=%b in_ready=%b, required 0 0 0", nm, out_valid, busy, in_ready);
    end
    step();
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s idle_no_queue: busy=%b in_ready=%b, required 0 0", nm, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== '0 || saturated !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%0d saturated=%b busy=%b, required all 0",
               in_ready, out_valid, result, saturated, busy);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_full_scale();
    fill_const(8'hFF, 12'h800);
    run_vector("full_scale", 40'sd0, 0, 0, 1'b0);
  endtask

  task automatic test_bubbles_bias();
    for (int j = 0; j < LEN; j++) begin
      va[j] = {8'd4, 8'd3, 8'd2, 8'd1};
      vb[j] = {12'd1, 12'd1, 12'd1, 12'd1};
    end
    run_vector("bubbles_bias", 40'sd100, 2, 0, 1'b0);
  endtask

  task automatic test_unsigned_a();
    fill_const(8'h80, 12'hFFF);
    run_vector("unsigned_a", 40'sd0, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_random();
    run_vector("backpressure", 40'sd12345, 1, 5, 1'b1);
  endtask

  task automatic test_reset_mid();
    fill_random();
    start = 1'b1;
    bias  = 40'sd777;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    a = va[0];
    b = vb[0];
    step();
    a = va[1];
    b = vb[1];
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      fails++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b result=%0d, required 0 0 0 0",
               in_ready, out_valid, busy, result);
    end
    step();
    fill_const(8'd2, 12'd3);
    run_vector("after_reset", 40'sd5, 0, 0, 1'b0);
  endtask

  task automatic test_saturation();
    fill_const(8'hFF, 12'h7FF);
    run_vector("sat_high", 40'sd2147483000, 0, 0, 1'b0);
    fill_const(8'hFF, 12'h800);
    run_vector("sat_low", -40'sd2147483000, 0, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 12; n++) begin
      fill_random();
      if (n % 2 == 0)
        run_vector("random", $signed(40'($signed($urandom()))), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
      else
        run_vector("random_wide", $signed(40'({$urandom(), $urandom()})), $urandom_range(0, 1), $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_bubbles_bias();
    test_unsigned_a();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
